// File: rtl/henon_pkg.sv
// Shared definitions for the Henon PRNG: FSM encoding, coefficient defaults
// and the rounding/saturation helpers used by the step datapath.
package henon_pkg;

  localparam int MAXW        = 64;
  localparam int STEP_STAGES = 3;

  typedef logic signed [2*MAXW-1:0] wide_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_ISSUE, ST_WAIT, ST_OUT, ST_DONE
  } state_e;

  // a = 1.4 in Q2.(w-2), rounded to nearest
  function automatic logic [MAXW-1:0] a_coef_def(input int unsigned w);
    return ((64'd7 << (w - 2)) + 64'd2) / 64'd5;
  endfunction

  // b = 0.3 in Q1.(w-1), rounded to nearest
  function automatic logic [MAXW-1:0] b_coef_def(input int unsigned w);
    return ((64'd3 << (w - 1)) + 64'd5) / 64'd10;
  endfunction

  function automatic wide_t rnd_shr(input wide_t v, input int unsigned sh);
    return (v + (wide_t'(1) <<< (sh - 1))) >>> sh;
  endfunction

  function automatic wide_t sat_w(input wide_t v, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/henon_step.sv
// One Henon iteration as a 3-stage pipeline: x' = sat(1 - a*x^2 + y + p),
// y' = sat(b*x). Only one step is in flight; start is ignored while busy.
module henon_step
  import henon_pkg::*;
#(
  parameter int           W      = 32,
  parameter logic [W-1:0] A_COEF = W'(a_coef_def(W)),
  parameter logic [W-1:0] B_COEF = W'(b_coef_def(W))
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [W-1:0] p_i,
  output logic         done,
  output logic [W-1:0] x_o,
  output logic [W-1:0] y_o
);

  logic [STEP_STAGES-1:0] vld_pipe_q, vld_pipe_d;
  logic signed [W:0]      x2_q, x2_d;
  logic signed [W-1:0]    bx_q, bx_d, y_q, y_d, p_q, p_d;
  logic signed [W+1:0]    ax2_q, ax2_d;
  logic signed [W+2:0]    sum3;
  logic [W-1:0]           xn_q, xn_d, yn_q, yn_d;

  always_comb begin
    vld_pipe_d = {vld_pipe_q[STEP_STAGES-2:0], start & ~(|vld_pipe_q)};
    x2_d  = x2_q;
    bx_d  = bx_q;
    y_d   = y_q;
    p_d   = p_q;
    ax2_d = ax2_q;
    xn_d  = xn_q;
    yn_d  = yn_q;
    // s1: x^2 needs one extra integer bit since (-1)^2 = +1.0
    if (vld_pipe_d[0]) begin
      x2_d = (W+1)'(rnd_shr(wide_t'($signed(x_i)) * wide_t'($signed(x_i)), W - 1));
      bx_d = W'(sat_w(rnd_shr(wide_t'($signed(x_i)) * wide_t'($signed({1'b0, B_COEF})),
                              W - 1), W));
      y_d  = y_i;
      p_d  = p_i;
    end
    if (vld_pipe_q[0])
      ax2_d = (W+2)'(rnd_shr(wide_t'(x2_q) * wide_t'($signed({1'b0, A_COEF})), W - 2));
    sum3 = (W+3)'((wide_t'(1) <<< (W - 1)) - wide_t'(ax2_q) + wide_t'(y_q) + wide_t'(p_q));
    if (vld_pipe_q[1]) begin
      xn_d = W'(sat_w(wide_t'(sum3), W));
      yn_d = bx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      x2_q       <= '0;
      bx_q       <= '0;
      y_q        <= '0;
      p_q        <= '0;
      ax2_q      <= '0;
      xn_q       <= '0;
      yn_q       <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      x2_q       <= x2_d;
      bx_q       <= bx_d;
      y_q        <= y_d;
      p_q        <= p_d;
      ax2_q      <= ax2_d;
      xn_q       <= xn_d;
      yn_q       <= yn_d;
    end
  end

  assign done = vld_pipe_q[STEP_STAGES-1];
  assign x_o  = xn_q;
  assign y_o  = yn_q;

endmodule

// File: rtl/henon_prng_stream.sv
// Henon PRNG run controller: burn-in of n_iter steps, then one sample
// (ONESHOT) or one fresh step per accepted sample (STREAM).
module henon_prng_stream
  import henon_pkg::*;
#(
  parameter int           W      = 32,
  parameter int           SEED_W = 16,
  parameter int           ITER_W = 8,
  parameter logic [W-1:0] A_COEF = W'(a_coef_def(W)),
  parameter logic [W-1:0] B_COEF = W'(b_coef_def(W))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [SEED_W-1:0] seed,
  input  logic [W-1:0]      fp_mean,
  input  logic [ITER_W-1:0] n_iter,
  input  logic [W-1:0]      perturb,
  output logic [W-1:0]      out_x,
  output logic [W-1:0]      out_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ITER_W:0] CNT_ONE = (ITER_W+1)'(1);

  state_e            state_q, state_d;
  logic              start_q, start_d;
  logic              mode_q, mode_d;
  logic              stop_seen_q, stop_seen_d;
  logic              out_valid_q, out_valid_d;
  logic [ITER_W-1:0] n_eff_q, n_eff_d;
  logic [ITER_W:0]   cnt_q, cnt_d, cnt_inc;
  logic [W-1:0]      perturb_q, perturb_d, x_q, x_d, y_q, y_d;
  logic [W-1:0]      out_x_q, out_x_d, out_y_q, out_y_d;
  logic              step_start, step_done, hs;
  logic [W-1:0]      step_x, step_y;

  henon_step #(.W(W), .A_COEF(A_COEF), .B_COEF(B_COEF)) u_step (
    .clk   (clk),
    .rst   (rst),
    .start (step_start),
    .x_i   (x_q),
    .y_i   (y_q),
    .p_i   (perturb_q),
    .done  (step_done),
    .x_o   (step_x),
    .y_o   (step_y)
  );

  always_comb begin
    state_d     = state_q;
    start_d     = start;
    mode_d      = mode_q;
    stop_seen_d = stop_seen_q;
    out_valid_d = out_valid_q;
    n_eff_d     = n_eff_q;
    cnt_d       = cnt_q;
    perturb_d   = perturb_q;
    x_d         = x_q;
    y_d         = y_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    step_start  = 1'b0;
    cnt_inc     = cnt_q + CNT_ONE;
    hs          = out_valid_q & out_ready;
    case (state_q)
      ST_IDLE: if (start && !start_q) begin
        // everything is captured on the edge so later input changes are ignored
        state_d   = ST_LOAD;
        mode_d    = mode;
        n_eff_d   = (n_iter == '0) ? ITER_W'(1) : n_iter;
        perturb_d = perturb;
        x_d       = W'(seed) << (W - SEED_W);
        y_d       = fp_mean;
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        step_start = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: if (step_done) begin
        x_d = step_x;
        y_d = step_y;
        // cnt stops at n_eff-1, so each later STREAM step goes straight to OUT
        if (cnt_inc < {1'b0, n_eff_q}) begin
          cnt_d   = cnt_inc;
          state_d = ST_ISSUE;
        end else begin
          out_x_d     = step_x;
          out_y_d     = step_y;
          out_valid_d = 1'b1;
          stop_seen_d = 1'b0;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        if (stop && mode_q) stop_seen_d = 1'b1;
        if (hs) begin
          out_valid_d = 1'b0;
          state_d     = (!mode_q || stop_seen_q || stop) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      mode_q      <= 1'b0;
      stop_seen_q <= 1'b0;
      out_valid_q <= 1'b0;
      n_eff_q     <= '0;
      cnt_q       <= '0;
      perturb_q   <= '0;
      x_q         <= '0;
      y_q         <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      mode_q      <= mode_d;
      stop_seen_q <= stop_seen_d;
      out_valid_q <= out_valid_d;
      n_eff_q     <= n_eff_d;
      cnt_q       <= cnt_d;
      perturb_q   <= perturb_d;
      x_q         <= x_d;
      y_q         <= y_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
    end
  end

  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_henon_prng_stream.sv
// Directed bench for henon_prng_stream: hand-computed ONESHOT results and
// latencies, a STREAM run with stalls and stop, and a mid-run reset.
module tb_henon_prng_stream;

  logic        clk = 1'b0;
  logic        rst, start, stop, mode, out_ready;
  logic [15:0] seed;
  logic [31:0] fp_mean, perturb, out_x, out_y;
  logic [7:0]  n_iter;
  logic        out_valid, busy, done;

  int n_chk  = 0;
  int n_fail = 0;
  bit hold_start = 1'b0;

  localparam longint A_C = 64'sh5999999A;
  localparam longint B_C = 64'sh26666666;

  always #5 clk = ~clk;

  henon_prng_stream dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .seed(seed),
    .fp_mean(fp_mean), .n_iter(n_iter), .perturb(perturb), .out_x(out_x),
    .out_y(out_y), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .done(done)
  );

  task automatic chk(input string tag, input longint obs, input longint exp,
                     input longint tol = 0);
    longint d;
    n_chk++;
    d = obs - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic longint rnd(input longint v, input int s);
    return (v + (64'sd1 <<< (s - 1))) >>> s;
  endfunction

  function automatic longint sat32(input longint v);
    if (v > 64'sh7FFFFFFF) return 64'sh7FFFFFFF;
    if (v < -64'sh80000000) return -64'sh80000000;
    return v;
  endfunction

  task automatic mstep(inout longint x, inout longint y, input longint p);
    longint nx;
    nx = sat32(64'sh80000000 - rnd(A_C * rnd(x * x, 31), 30) + y + p);
    y  = sat32(rnd(B_C * x, 31));
    x  = nx;
  endtask

  task automatic launch(input logic [15:0] sd, input logic [31:0] fm, input logic [31:0] pt,
                        input logic [7:0] ni, input logic md);
    @(negedge clk);
    seed = sd; fp_mean = fm; perturb = pt; n_iter = ni; mode = md;
    start = 1'b1;
  endtask

  // lat counts cycles from the start-sampling edge until out_valid is seen
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!hold_start) start = 1'b0;
    end while (!out_valid && lat < 2000);
  endtask

  task automatic finish_oneshot(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_vld_drop"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int lat, k, rc, cyc;
    bit stalled, stop_sent, fin, done_seen;
    logic [31:0] hx, hy;
    logic [3:0] pat;
    longint mx, my;

    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; out_ready = 1'b0;
    seed = '0; fp_mean = '0; perturb = '0; n_iter = '0;
    repeat (3) @(negedge clk);
    chk("rst_x", out_x, 0);
    chk("rst_y", out_y, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    // 1: x' = 1.0 saturates
    launch(16'h0, 32'h0, 32'h0, 8'd1, 1'b0);
    wait_valid(lat);
    chk("t1_lat", lat, 6);
    chk("t1_x", out_x, 32'h7FFFFFFF);
    chk("t1_y", out_y, 0);
    repeat (2) @(negedge clk);
    chk("t1_hold_vld", out_valid, 1);
    chk("t1_hold_x", out_x, 32'h7FFFFFFF);
    finish_oneshot("t1");

    // 2: second step lands near -0.4 / 0.3
    launch(16'h0, 32'h0, 32'h0, 8'd2, 1'b0);
    wait_valid(lat);
    chk("t2_lat", lat, 10);
    chk("t2_x", out_x, 32'hCCCCCCCD, 2);
    chk("t2_y", out_y, 32'h26666666, 2);
    finish_oneshot("t2");

    // 3: n_iter=0 runs once; start held high must not retrigger
    hold_start = 1'b1;
    launch(16'h0, 32'h0, 32'hC0000000, 8'd0, 1'b0);
    wait_valid(lat);
    chk("t3_lat", lat, 6);
    chk("t3_x", out_x, 32'h40000000);
    chk("t3_y", out_y, 0);
    finish_oneshot("t3");
    @(negedge clk);
    chk("t3_no_retrig", busy, 0);
    hold_start = 1'b0;
    start = 1'b0;

    // max burn-in count, against the software model
    mx = longint'($signed({16'h2000, 16'h0}));
    my = longint'($signed(32'h10000000));
    for (int i = 0; i < 255; i++) mstep(mx, my, 0);
    launch(16'h2000, 32'h10000000, 32'h0, 8'hFF, 1'b0);
    wait_valid(lat);
    chk("nmax_lat", lat, 1022);
    chk("nmax_x", out_x, {32'h0, mx[31:0]});
    chk("nmax_y", out_y, {32'h0, my[31:0]});
    finish_oneshot("nmax");

    // 4+5: STREAM with ready pattern 1-0-0-1, stop pulsed during a stall
    mx = longint'($signed({16'h1234, 16'h0}));
    my = longint'($signed(32'h08000000));
    for (int i = 0; i < 8; i++) mstep(mx, my, longint'($signed(32'h01000000)));
    launch(16'h1234, 32'h08000000, 32'h01000000, 8'd8, 1'b1);
    wait_valid(lat);
    chk("t4_lat", lat, 34);
    pat = 4'b1001;
    k = 0; rc = 0; cyc = 0; stalled = 0; stop_sent = 0; fin = 0;
    hx = '0; hy = '0;
    while (!fin && cyc < 300) begin
      if (out_valid) begin
        if (stalled) begin
          chk("t4_stall_x", out_x, hx);
          chk("t4_stall_y", out_y, hy);
        end
        if (pat[rc % 4]) begin
          chk($sformatf("t4_s%0d_x", k), out_x, {32'h0, mx[31:0]});
          chk($sformatf("t4_s%0d_y", k), out_y, {32'h0, my[31:0]});
          mstep(mx, my, longint'($signed(32'h01000000)));
          k++;
          out_ready = 1'b1;
          stalled = 0;
          if (stop_sent) fin = 1;
        end else begin
          out_ready = 1'b0;
          stalled = 1;
          hx = out_x; hy = out_y;
          if (k == 5 && !stop_sent) begin
            stop = 1'b1;
            stop_sent = 1;
          end
        end
        rc++;
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
      stop = 1'b0;
      cyc++;
    end
    out_ready = 1'b0;
    chk("t5_finished", fin, 1);
    chk("t5_samples", k, 6);
    chk("t5_done", done, 1);
    chk("t5_vld_drop", out_valid, 0);
    @(negedge clk);
    chk("t5_done_1cyc", done, 0);
    chk("t5_idle", busy, 0);

    // 6: reset in WAIT aborts silently
    launch(16'h0, 32'h0, 32'h0, 8'd2, 1'b0);
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("t6_in_run", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_x", out_x, 0);
    chk("t6_y", out_y, 0);
    chk("t6_vld", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    rst = 1'b0;
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) done_seen = 1;
    end
    chk("t6_quiet", done_seen, 0);
    launch(16'h0, 32'h0, 32'h0, 8'd2, 1'b0);
    wait_valid(lat);
    chk("t6_rerun_lat", lat, 10);
    chk("t6_rerun_x", out_x, 32'hCCCCCCCD, 2);
    chk("t6_rerun_y", out_y, 32'h26666666, 2);
    finish_oneshot("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
